// File: rtl/sattn_mmio_host.sv
// sattn_mmio_host: runs one sparse-attention job over the accelerator's MMIO slave port:
// shape writes, index RAM load, command, done polling, checksum read, then a held response.
module sattn_mmio_host #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_cmd,
  input  logic [15:0]           req_m_rows,
  input  logic [15:0]           req_head_d,
  input  logic [15:0]           req_s_tokens,
  input  logic [15:0]           req_block_sz,
  input  logic [15:0]           req_k_blocks,
  input  logic [15:0]           req_idx_count,
  input  logic                  idx_valid,
  output logic                  idx_ready,
  input  logic [15:0]           idx_data,
  output logic                  mmio_wen,
  output logic                  mmio_ren,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_sum,
  output logic                  rsp_timeout,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] A_M_ROWS   = ADDR_WIDTH'(16'h30);
  localparam logic [ADDR_WIDTH-1:0] A_HEAD_D   = ADDR_WIDTH'(16'h38);
  localparam logic [ADDR_WIDTH-1:0] A_BLOCK_SZ = ADDR_WIDTH'(16'h40);
  localparam logic [ADDR_WIDTH-1:0] A_K_BLOCKS = ADDR_WIDTH'(16'h48);
  localparam logic [ADDR_WIDTH-1:0] A_S_TOKENS = ADDR_WIDTH'(16'h50);
  localparam logic [ADDR_WIDTH-1:0] A_CMD      = ADDR_WIDTH'(16'h60);
  localparam logic [ADDR_WIDTH-1:0] A_SUM_ACC  = ADDR_WIDTH'(16'h68);
  localparam logic [ADDR_WIDTH-1:0] A_IDX_ADDR = ADDR_WIDTH'(16'h70);
  localparam logic [ADDR_WIDTH-1:0] A_IDX_DATA = ADDR_WIDTH'(16'h78);
  localparam logic [ADDR_WIDTH-1:0] A_SUM_15   = ADDR_WIDTH'(16'h80);
  localparam logic [ADDR_WIDTH-1:0] A_SUM_16   = ADDR_WIDTH'(16'h88);
  localparam logic [31:0]           TO_LIMIT   = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_IDX_A, S_IDX_D, S_CMD, S_WAIT, S_READ, S_RESP
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cmd;
  logic [15:0] r_m_rows, r_head_d, r_s_tokens, r_block_sz, r_k_blocks, r_idx_count;
  logic [2:0]  r_cfg_cnt;
  logic [15:0] r_idx_cnt;
  logic [15:0] r_poll_cnt;
  logic [63:0] r_sum;
  logic        r_timeout;

  logic                  w_wen, w_ren, w_idx_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_nop, w_last_idx, w_poll_hit, w_csum_hit;
  logic [15:0]           w_poll_inc;
  logic [ADDR_WIDTH-1:0] w_csum_addr;
  state_t                w_after_idx;

  assign w_nop       = (r_cmd == 8'h00);
  assign w_last_idx  = (r_idx_cnt == r_idx_count - 16'd1);
  assign w_after_idx = w_nop ? S_RESP : S_CMD;
  assign w_poll_inc  = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
  assign w_poll_hit  = ({16'd0, w_poll_inc} >= TO_LIMIT);

  // Each checksum opcode has its own result register; other opcodes report zero.
  always_comb begin
    w_csum_hit  = 1'b1;
    w_csum_addr = A_SUM_ACC;
    case (r_cmd)
      8'h14:   w_csum_addr = A_SUM_ACC;
      8'h15:   w_csum_addr = A_SUM_15;
      8'h16:   w_csum_addr = A_SUM_16;
      default: w_csum_hit  = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_wen       = 1'b0;
    w_ren       = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_idx_ready = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) w_next = S_CFG;
      S_CFG: begin
        w_wen = 1'b1;
        case (r_cfg_cnt)
          3'd0:    begin w_addr = A_M_ROWS;   w_wdata = DATA_WIDTH'(r_m_rows);   end
          3'd1:    begin w_addr = A_HEAD_D;   w_wdata = DATA_WIDTH'(r_head_d);   end
          3'd2:    begin w_addr = A_S_TOKENS; w_wdata = DATA_WIDTH'(r_s_tokens); end
          3'd3:    begin w_addr = A_BLOCK_SZ; w_wdata = DATA_WIDTH'(r_block_sz); end
          default: begin w_addr = A_K_BLOCKS; w_wdata = DATA_WIDTH'(r_k_blocks); end
        endcase
        if (r_cfg_cnt == 3'd4) w_next = (r_idx_count != 16'd0) ? S_IDX_A : w_after_idx;
      end
      S_IDX_A: begin
        w_wen   = 1'b1;
        w_addr  = A_IDX_ADDR;
        w_wdata = DATA_WIDTH'(r_idx_cnt);
        w_next  = S_IDX_D;
      end
      S_IDX_D: if (idx_valid) begin
        w_wen       = 1'b1;
        w_addr      = A_IDX_DATA;
        w_wdata     = DATA_WIDTH'(idx_data);
        w_idx_ready = 1'b1;
        w_next      = w_last_idx ? w_after_idx : S_IDX_A;
      end
      S_CMD: begin
        w_wen   = 1'b1;
        w_addr  = A_CMD;
        w_wdata = DATA_WIDTH'(r_cmd);
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        w_ren  = 1'b1;
        w_addr = A_CMD;
        if (mmio_rdata[0])   w_next = S_READ;
        else if (w_poll_hit) w_next = S_RESP;
      end
      S_READ: begin
        w_ren  = w_csum_hit;
        w_addr = w_csum_hit ? w_csum_addr : '0;
        w_next = S_RESP;
      end
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_m_rows    <= '0;
      r_head_d    <= '0;
      r_s_tokens  <= '0;
      r_block_sz  <= '0;
      r_k_blocks  <= '0;
      r_idx_count <= '0;
      r_cfg_cnt   <= '0;
      r_idx_cnt   <= '0;
      r_poll_cnt  <= '0;
      r_sum       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_cmd       <= req_cmd;
          r_m_rows    <= req_m_rows;
          r_head_d    <= req_head_d;
          r_s_tokens  <= req_s_tokens;
          r_block_sz  <= req_block_sz;
          r_k_blocks  <= req_k_blocks;
          r_idx_count <= req_idx_count;
          r_cfg_cnt   <= '0;
          r_idx_cnt   <= '0;
          r_poll_cnt  <= '0;
          r_sum       <= '0;
          r_timeout   <= 1'b0;
        end
        S_CFG:   r_cfg_cnt <= r_cfg_cnt + 3'd1;
        S_IDX_D: if (idx_valid) r_idx_cnt <= r_idx_cnt + 16'd1;
        S_CMD:   r_poll_cnt <= '0;
        S_WAIT: if (!mmio_rdata[0]) begin
          r_poll_cnt <= w_poll_inc;
          if (w_poll_hit) r_timeout <= 1'b1;
        end
        // Slave latched its checksum on the DONE cycle, so the read lands one cycle later.
        S_READ: if (w_csum_hit) r_sum <= 64'(mmio_rdata);
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign idx_ready   = w_idx_ready;
  assign mmio_wen    = w_wen;
  assign mmio_ren    = w_ren;
  assign mmio_addr   = w_addr;
  assign mmio_wdata  = w_wdata;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_sum     = r_sum;
  assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_sattn_mmio_host.sv
// Bench for sattn_mmio_host: directed and random jobs against a slave model and a
// descriptor-level reference of the expected MMIO trace and response.
module tb_sattn_mmio_host;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd;
  logic [15:0] req_m_rows, req_head_d, req_s_tokens, req_block_sz, req_k_blocks, req_idx_count;
  logic        idx_valid, idx_ready;
  logic [15:0] idx_data;
  logic        mmio_wen, mmio_ren;
  logic [15:0] mmio_addr;
  logic [63:0] mmio_wdata, mmio_rdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_sum;
  logic        rsp_timeout, busy;

  always #5 clk = ~clk;

  sattn_mmio_host #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_m_rows(req_m_rows), .req_head_d(req_head_d), .req_s_tokens(req_s_tokens),
    .req_block_sz(req_block_sz), .req_k_blocks(req_k_blocks), .req_idx_count(req_idx_count),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
    .mmio_wen(mmio_wen), .mmio_ren(mmio_ren), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: done pulses once, j_delay cycles after the command write.
  int          cyc = 0;
  int          done_delay = 1;
  int          done_cyc = -1;
  logic [63:0] s68, s80, s88;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    mmio_rdata = '0;
    if (mmio_ren) begin
      case (mmio_addr)
        16'h60:  mmio_rdata = {63'd0, (cyc == done_cyc)};
        16'h68:  mmio_rdata = s68;
        16'h80:  mmio_rdata = s80;
        16'h88:  mmio_rdata = s88;
        default: mmio_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      endcase
    end
  end

  // Observation log for the current job
  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];
  int          wc_q[$];
  logic [15:0] ra_q[$];
  int          rc_q[$];
  int          rdy_pulses, viol, rsp_cycles, rsp_first, acc_cyc, rst_strobes;
  logic [63:0] rsp_sum0;
  logic        rsp_to0;

  // Index stream source
  logic [15:0] idx_q[$];
  int          stall_q[$];
  int          stalled = 0;
  logic        idx_took = 1'b0;

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
    rdy_pulses = 0; viol = 0; rsp_cycles = 0; rsp_first = -1; acc_cyc = -1;
    rsp_sum0 = '0; rsp_to0 = 1'b0;
  endtask

  initial begin
    idx_valid = 1'b0;
    idx_data  = 16'hDEAD;
    forever begin
      @(negedge clk);
      idx_took = 1'b0;
      if (!rstn) begin
        if (mmio_wen || mmio_ren || rsp_valid) rst_strobes++;
      end else begin
        if (mmio_wen && mmio_ren) viol++;
        if (!mmio_wen && !mmio_ren && (mmio_addr != 16'd0 || mmio_wdata != 64'd0)) viol++;
        if (busy == req_ready) viol++;
        if (req_valid && req_ready) acc_cyc = cyc;
        if (mmio_wen) begin
          wa_q.push_back(mmio_addr); wd_q.push_back(mmio_wdata); wc_q.push_back(cyc);
          if (mmio_addr == 16'h60) done_cyc = cyc + done_delay;
        end
        if (mmio_ren) begin ra_q.push_back(mmio_addr); rc_q.push_back(cyc); end
        if (idx_ready) begin
          rdy_pulses++;
          if (!idx_valid) viol++;
        end
        idx_took = idx_valid && idx_ready;
        if (rsp_valid) begin
          if (rsp_cycles == 0) begin
            rsp_first = cyc; rsp_sum0 = rsp_sum; rsp_to0 = rsp_timeout;
          end else if (rsp_sum !== rsp_sum0 || rsp_timeout !== rsp_to0) viol++;
          rsp_cycles++;
        end
      end
      @(posedge clk);
      #1;
      if (idx_took && idx_q.size() > 0) begin
        void'(idx_q.pop_front()); void'(stall_q.pop_front()); stalled = 0;
      end
      if (idx_q.size() == 0) begin
        idx_valid = 1'b0; idx_data = 16'hDEAD;
      end else if (stalled < stall_q[0]) begin
        idx_valid = 1'b0; idx_data = 16'hDEAD; stalled++;
      end else begin
        idx_valid = 1'b1; idx_data = idx_q[0];
      end
    end
  end

  // Current job descriptor
  logic [7:0]  j_cmd;
  logic [15:0] j_m, j_d, j_s, j_bs, j_kb;
  int          j_n, j_delay, j_rdly;
  logic [15:0] j_idx[16];
  int          j_stall[16];

  task automatic start_job();
    clear_log();
    done_delay = j_delay;
    done_cyc   = -1;
    stalled    = 0;
    for (int i = 0; i < j_n; i++) begin idx_q.push_back(j_idx[i]); stall_q.push_back(j_stall[i]); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_cmd = j_cmd;
    req_m_rows = j_m; req_head_d = j_d; req_s_tokens = j_s; req_block_sz = j_bs; req_k_blocks = j_kb;
    req_idx_count = 16'(j_n);
    @(posedge clk); #1;
    req_valid = 1'b0; req_cmd = $urandom(); req_idx_count = $urandom();
  endtask

  task automatic finish_job();
    logic [15:0] ewa[$];
    logic [63:0] ewd[$];
    logic        ok, e_to, e_csum, nostall;
    logic [15:0] e_caddr;
    logic [63:0] e_sum;
    int          e_polls, n_polls, n_csum, gaps, last_poll, csum_cyc;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("rsp_arrives", 64'(ok), 64'd1);
    repeat (j_rdly) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after", 64'(req_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);

    // Reference: descriptor -> write trace, poll count, response
    ewa = '{16'h30, 16'h38, 16'h50, 16'h40, 16'h48};
    ewd = '{64'(j_m), 64'(j_d), 64'(j_s), 64'(j_bs), 64'(j_kb)};
    for (int i = 0; i < j_n; i++) begin
      ewa.push_back(16'h70); ewd.push_back(64'(i));
      ewa.push_back(16'h78); ewd.push_back(64'(j_idx[i]));
    end
    if (j_cmd != 8'h00) begin ewa.push_back(16'h60); ewd.push_back(64'(j_cmd)); end
    e_to    = (j_cmd != 8'h00) && (j_delay > TO);
    e_polls = (j_cmd == 8'h00) ? 0 : (e_to ? TO : j_delay);
    e_csum  = !e_to && (j_cmd == 8'h14 || j_cmd == 8'h15 || j_cmd == 8'h16);
    e_caddr = (j_cmd == 8'h14) ? 16'h68 : (j_cmd == 8'h15) ? 16'h80 : 16'h88;
    e_sum   = !e_csum ? 64'd0 : (j_cmd == 8'h14) ? s68 : (j_cmd == 8'h15) ? s80 : s88;

    chk("n_writes", 64'(wa_q.size()), 64'(ewa.size()));
    for (int i = 0; i < wa_q.size() && i < ewa.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), 64'(wa_q[i]), 64'(ewa[i]));
      chk($sformatf("wr%0d_data", i), wd_q[i], ewd[i]);
    end
    n_polls = 0; n_csum = 0; gaps = 0; last_poll = -1; csum_cyc = -1;
    for (int i = 0; i < ra_q.size(); i++) begin
      if (ra_q[i] == 16'h60) begin
        if (last_poll >= 0 && rc_q[i] != last_poll + 1) gaps++;
        n_polls++; last_poll = rc_q[i];
      end else begin
        n_csum++; csum_cyc = rc_q[i];
        chk("csum_addr", 64'(ra_q[i]), 64'(e_caddr));
      end
    end
    chk("n_polls", 64'(n_polls), 64'(e_polls));
    chk("poll_gaps", 64'(gaps), 64'd0);
    chk("n_csum_reads", 64'(n_csum), 64'(e_csum));
    chk("rsp_sum", rsp_sum0, e_sum);
    chk("rsp_timeout", 64'(rsp_to0), 64'(e_to));
    chk("rsp_hold", 64'(rsp_cycles), 64'(j_rdly + 1));
    chk("idx_ready_pulses", 64'(rdy_pulses), 64'(j_n));
    chk("protocol_viol", 64'(viol), 64'd0);
    nostall = 1'b1;
    for (int i = 0; i < j_n; i++) if (j_stall[i] != 0) nostall = 1'b0;
    if (nostall && wc_q.size() > 0) begin
      chk("lat_cfg", 64'(wc_q[0] - acc_cyc), 64'd1);
      if (j_cmd != 8'h00) chk("lat_cmd", 64'(wc_q[wc_q.size()-1] - acc_cyc), 64'(6 + 2 * j_n));
    end
    if (j_cmd != 8'h00 && last_poll >= 0)
      chk("lat_rsp", 64'(rsp_first - last_poll), e_to ? 64'd1 : 64'd2);
    if (n_csum == 1) chk("lat_rsp_read", 64'(rsp_first - csum_cyc), 64'd1);
  endtask

  task automatic set_job(input logic [7:0] c, input int n, input int dly, input int rdly);
    j_cmd = c; j_n = n; j_delay = dly; j_rdly = rdly;
    j_m = 16'd2; j_d = 16'd4; j_s = 16'd4; j_bs = 16'd2; j_kb = 16'd1;
    for (int i = 0; i < 16; i++) begin j_idx[i] = 16'(i * 3 + 1); j_stall[i] = 0; end
  endtask

  initial begin
    logic [7:0] ops[6];
    logic       reached;
    ops = '{8'h00, 8'h10, 8'h13, 8'h14, 8'h15, 8'h16};
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_cmd = '0; req_m_rows = '0; req_head_d = '0; req_s_tokens = '0;
    req_block_sz = '0; req_k_blocks = '0; req_idx_count = '0;
    s68 = 64'h1234; s80 = 64'hAA; s88 = 64'hBB;
    rst_strobes = 0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({mmio_wen, mmio_ren, idx_ready, rsp_valid}), 64'd0);
    chk("rst_rsp", {rsp_sum[62:0], rsp_timeout}, 64'd0);
    @(negedge clk) rstn = 1'b1;

    set_job(8'h14, 2, 20, 0); j_idx[0] = 16'd5; j_idx[1] = 16'd7;
    start_job(); finish_job();
    set_job(8'h15, 1, 3, 1); start_job(); finish_job();
    set_job(8'h16, 0, 7, 2); start_job(); finish_job();
    set_job(8'h14, 2, 100000, 0); start_job(); finish_job();
    set_job(8'h13, 3, 1, 0); j_stall[1] = 3; start_job(); finish_job();
    set_job(8'h00, 2, 5, 5); start_job(); finish_job();
    set_job(8'h10, 1, 64, 0); start_job(); finish_job();

    // Reset in the middle of polling
    set_job(8'h14, 1, 100000, 0); start_job();
    reached = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (ra_q.size() >= 3) begin reached = 1'b1; break; end
    end
    chk("reached_wait", 64'(reached), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_strobes", 64'({mmio_wen, mmio_ren, rsp_valid}), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    rst_strobes = 0;
    idx_q.delete(); stall_q.delete(); done_cyc = -1;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_no_traffic", 64'(rst_strobes), 64'd0);
    set_job(8'h15, 2, 4, 1); start_job(); finish_job();

    for (int k = 0; k < 25; k++) begin
      set_job(ops[$urandom_range(0, 5)], $urandom_range(0, 4), $urandom_range(1, 90), $urandom_range(0, 3));
      j_m = $urandom(); j_d = $urandom(); j_s = $urandom(); j_bs = $urandom(); j_kb = $urandom();
      for (int i = 0; i < j_n; i++) begin
        j_idx[i] = $urandom();
        j_stall[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      end
      s68 = {$urandom(), $urandom()}; s80 = {$urandom(), $urandom()}; s88 = {$urandom(), $urandom()};
      start_job(); finish_job();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/sattn_mmio_host.md
Name: sattn_mmio_host

Overview:
MMIO initiator that drives the sparse-attention accelerator's register-file slave port. It accepts one job descriptor plus a stream of block indices. It programs the shape registers, loads the index RAM through the WADDR/WDATA pair, and issues the command. It then polls status until done or timeout, reads the matching checksum register and returns a response. It sits between the test or host sequencer and the accelerator, replacing hand-written MMIO sequences.

Parameters:
ADDR_WIDTH, 16, MMIO address width
DATA_WIDTH, 64, MMIO data width
TIMEOUT_CYCLES, 4096, maximum poll cycles in WAIT before the job is abandoned

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  job descriptor valid
req_ready  out  1  host idle, can accept a job
req_cmd  in  8  command opcode (0x00 NOP, 0x10-0x16)
req_m_rows / req_head_d / req_s_tokens / req_block_sz / req_k_blocks  in  16 each  shape fields
req_idx_count  in  16  number of index entries to load
idx_valid  in  1  index stream data valid
idx_ready  out  1  index word consumed this cycle
idx_data  in  16  index value
mmio_wen  out  1  MMIO write strobe
mmio_ren  out  1  MMIO read strobe
mmio_addr  out  ADDR_WIDTH  MMIO byte offset
mmio_wdata  out  DATA_WIDTH  MMIO write data
mmio_rdata  in  DATA_WIDTH  MMIO read data, combinational from slave
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_sum  out  64  checksum read back
rsp_timeout  out  1  job abandoned on timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous on rstn, as decided.
  - In reset: state IDLE; all outputs 0 except req_ready=1; counters and latched descriptor cleared.
  - Reset mid-job aborts with no response and no further MMIO traffic.
- MMIO outputs are decoded from registered state. Addr and wdata are 0 whenever wen and ren are both low.
  - At most one access per cycle; wen and ren are never both high.
  - Read data is sampled at the rising edge that ends the ren cycle.
- Handshakes:
  - Descriptor is latched on req_valid and req_ready; req_ready = (state==IDLE).
  - Response holds rsp_valid, rsp_sum and rsp_timeout stable until rsp_ready. It returns to IDLE on the accepting edge.
- States: IDLE -> CFG -> IDX -> CMD -> WAIT -> READ -> RESP -> IDLE.
- CFG: five consecutive write cycles, data zero-extended to 64 bits.
  - Order: 0x30 m_rows, 0x38 head_d, 0x50 s_tokens, 0x40 block_sz, 0x48 k_blocks.
- IDX: for i=0..idx_count-1, write 0x70 with data i, then 0x78 with idx_data.
  - The 0x78 write occurs only in a cycle with idx_valid=1. idx_ready is high only in that cycle.
  - While idx_valid=0 the host stays in the data phase with wen=0.
  - Pairs are back-to-back when data is available.
  - idx_count=0 skips IDX entirely.
- CMD: one write of 0x60 with data {56'd0, cmd}.
  - cmd=0x00 skips CMD, WAIT and READ and goes to RESP with sum=0 and timeout=0.
- WAIT: read 0x60 every cycle. The done bit is a one-cycle pulse, so polling has no gaps.
  - If rdata[0]==1, go to READ.
  - Otherwise increment the poll counter. When the counter reaches TIMEOUT_CYCLES, go to RESP with timeout=1 and sum=0.
  - The counter is 16 bits and saturates; it is cleared on entry to WAIT.
- READ: one read cycle, entered the cycle after done is seen, because the slave latches its checksum on its DONE cycle.
  - Address by cmd: 0x14 reads 0x68, 0x15 reads 0x80, 0x16 reads 0x88.
  - Any other non-NOP opcode performs no read and returns sum=0.
- Latency: descriptor accept at edge k.
  - First CFG write in cycle k+1.
  - CMD write in cycle k+6+2N, where N is idx_count with no stalls.
  - rsp_valid asserts the cycle after READ.

Test Plan:
- cmd 0x14, m=2, d=4, s=4, bs=2, kb=1, N=2 with idx 5,7; slave model goes done 20 cycles after CMD with ACC_SUM=0x1234.
  -> Exact write trace 0x30:2, 0x38:4, 0x50:4, 0x40:2, 0x48:1, 0x70:0, 0x78:5, 0x70:1, 0x78:7, 0x60:0x14.
  -> Polls continuously, then one read of 0x68; rsp_sum=0x1234, timeout=0.
- cmd 0x15 and cmd 0x16 with sums 0xAA and 0xBB -> reads 0x80 and 0x88 respectively; rsp_sum matches each.
- TIMEOUT_CYCLES=64, slave never done -> exactly 64 reads of 0x60, no checksum read, rsp_timeout=1, rsp_sum=0.
- N=3 with idx_valid low for 3 cycles before the second word -> wen low during the stall, each 0x78 written once, idx_ready pulses exactly 3 times.
- cmd 0x00 with rsp_ready low for 5 cycles -> no 0x60 access; rsp_valid held stable for 6 cycles; req_ready=0 until the accepting edge, then 1.
- rstn asserted during WAIT -> all MMIO strobes 0 immediately and rsp_valid=0; req_ready=1 after release; a new job runs normally.
